// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Default bound on consecutive data grants while a fetch is waiting.
    localparam int unsigned DEFAULT_MAX_DATA_STREAK = 4;

    // Byte-strobe pattern that denotes a read access.
    localparam logic [3:0] MEM_RD = 4'b0000;

    // Which requester owns the memory response arriving this cycle.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_I_RESP    = 2'd1,
        ST_D_RD_RESP = 2'd2,
        ST_D_WR_RESP = 2'd3
    } resp_state_t;

    // The memory is word-addressed; the low two byte-address bits are dropped.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : CPU fetch port, CPU data port and shared memory port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;

    // Instruction fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    // Data load/store port
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    // Shared memory port
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter view: takes CPU requests and memory read data, drives the rest.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Environment view: CPU requesters plus the memory macro.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_streak_counter.sv
`default_nettype none
// ============================================================================
// Module      : streak_counter
// Description : Saturating 4-bit counter of consecutive data grants taken
//               while an instruction fetch is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module streak_counter (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       inc,
    input  wire logic       clr,
    input  wire logic [3:0] limit,
    output logic            at_limit
);

    logic [3:0] r_count;

    // Clear wins over increment; the count never climbs past the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (clr) begin
            r_count <= 4'd0;
        end else if (inc && (r_count < limit)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign at_limit = (r_count == limit);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous memory between the CPU
//               fetch and data ports. Data has priority; a bounded data
//               streak guarantees fetch progress. One access per cycle, read
//               data routed back one cycle after the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] c_LIMIT = 4'(MAX_DATA_STREAK);

    logic        w_at_limit;
    logic        w_i_gnt;
    logic        w_d_gnt;
    logic        w_streak_inc;
    logic        w_streak_clr;
    resp_state_t r_state;
    resp_state_t w_state_next;

    // Grant decision: data first unless the fetch has waited a full streak.
    // Grants are suppressed while reset is asserted so every output reads 0.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (rst_n) begin
            if (bus.d_req && (!bus.i_req || !w_at_limit)) begin
                w_d_gnt = 1'b1;
            end else if (bus.i_req) begin
                w_i_gnt = 1'b1;
            end
        end
    end

    // Streak only counts data grants that made a waiting fetch wait longer.
    assign w_streak_inc = w_d_gnt & bus.i_req;
    assign w_streak_clr = w_i_gnt | ~bus.i_req;

    streak_counter u_streak (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_streak_inc),
        .clr      (w_streak_clr),
        .limit    (c_LIMIT),
        .at_limit (w_at_limit)
    );

    // Memory request mux; address and write data rest at 0 when idle.
    always_comb begin
        bus.i_gnt     = w_i_gnt;
        bus.d_gnt     = w_d_gnt;
        bus.mem_en    = w_i_gnt | w_d_gnt;
        bus.mem_we    = MEM_RD;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        if (w_d_gnt) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = word_addr(bus.d_addr);
            bus.mem_wdata = bus.d_wdata;
        end else if (w_i_gnt) begin
            bus.mem_addr  = word_addr(bus.i_addr);
        end
    end

    // Response owner register; reset discards any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next owner follows this cycle's grant; outputs route mem_rdata by owner.
    always_comb begin
        w_state_next = ST_IDLE;
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = 32'h0;
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = 32'h0;

        if (w_d_gnt) begin
            w_state_next = (bus.d_we == MEM_RD) ? ST_D_RD_RESP : ST_D_WR_RESP;
        end else if (w_i_gnt) begin
            w_state_next = ST_I_RESP;
        end

        case (r_state)
            ST_I_RESP: begin
                bus.i_rvalid = 1'b1;
                bus.i_rdata  = bus.mem_rdata;
            end
            ST_D_RD_RESP: begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = bus.mem_rdata;
            end
            ST_D_WR_RESP: begin
                bus.d_rvalid = 1'b1;
            end
            default: begin
                bus.i_rvalid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU's instruction-fetch port and data load/store port onto one shared single-port synchronous memory. It sits between the CPU and the memory macro. It issues at most one memory access per cycle, tracks the single outstanding read, and returns the read data to the requester that owns it. Data accesses have priority, and a bounded-streak rule guarantees instruction fetch is never starved.

## Interface
- MAX_DATA_STREAK, 4: maximum consecutive data grants while an instruction request waits (legal range 1..15).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction read request; held until granted.
- i_addr  in  32  instruction byte address.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid  out  1  i_rdata valid, one cycle after i_gnt.
- i_rdata  out  32  fetched instruction word.
- d_req  in  1  data request; held until granted.
- d_we  in  4  byte write strobes; 4'b0000 means read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, byte lanes already positioned.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  completion pulse one cycle after d_gnt, for both loads and stores.
- d_rdata  out  32  load data; 32'h0 for stores.
- mem_en  out  1  memory access enable.
- mem_we  out  4  memory byte write strobes.
- mem_addr  out  32  memory byte address, with [1:0] forced to 2'b00.
- mem_rdata  in  32  memory read data, valid the cycle after a read with mem_en=1.

## Operation
- Grant decision is combinational from i_req, d_req and the streak counter:
  - d_req only: data is granted.
  - i_req only: instruction is granted.
  - both asserted and streak < MAX_DATA_STREAK: data is granted, streak increments.
  - both asserted and streak == MAX_DATA_STREAK: instruction is granted, streak clears.
- Streak counter:
  - Clears on any instruction grant, and on any cycle with i_req=0.
  - Holds when there is no grant.
  - Width is 4 bits and never exceeds MAX_DATA_STREAK.
- A granted request drives mem_en=1, mem_addr, mem_we and mem_wdata in the same cycle.
  - Instruction grants always use mem_we=0.
  - With no grant: mem_en=0, mem_we=0, and mem_addr/mem_wdata are held at 0.
- Response FSM, registered:
  - States: IDLE, I_RESP, D_RD_RESP, D_WR_RESP.
  - The next state is set by the grant of the current cycle.
  - A new grant may be issued in any state, so the pipeline sustains one access per cycle.
- Return path by state:
  - I_RESP: i_rvalid=1, i_rdata=mem_rdata.
  - D_RD_RESP: d_rvalid=1, d_rdata=mem_rdata.
  - D_WR_RESP: d_rvalid=1, d_rdata=32'h0.
  - IDLE: all rdata outputs are 32'h0 and all rvalid outputs are 0.
- Misaligned addresses are not checked; bits [1:0] are dropped.

## Timing
- Reset values (asynchronous, applied while rst_n=0):
  - FSM=IDLE, streak=0.
  - i_gnt=d_gnt=i_rvalid=d_rvalid=0, mem_en=0, mem_we=0.
  - All data and address outputs are 0.
- Latency: a request granted in cycle T has rvalid asserted in cycle T+1. Throughput is one grant per cycle.
- i_gnt and d_gnt are never both 1 in the same cycle. Each is 0 whenever its req is 0.
- Requesters must keep req, addr, we and wdata stable until the cycle their gnt is seen high. They may drop or change them in the next cycle.
- Reset asserted while a read is in flight: the response is discarded and no rvalid appears after reset releases.
- After rst_n deasserts, the first grant may occur in the same cycle.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the response-state enum,
  - the `MEM_RD` constant for strobe 4'b0000,
  - the default MAX_DATA_STREAK value.
- One sub-module is natural: `streak_counter`, a saturating 4-bit counter with inc, clr and limit inputs and an at_limit output.

## Test plan
- Reset then i_req with i_addr=0x10, mem_rdata=0x00500093 → i_gnt in cycle 0, mem_addr=0x10; i_rvalid=1 and i_rdata=0x00500093 in cycle 1.
- d_req store with d_we=4'b0011, d_addr=0x106, d_wdata=0x0000BEEF → mem_addr=0x104, mem_we=4'b0011; d_rvalid=1 next cycle with d_rdata=0.
- i_req and d_req both held high continuously with MAX_DATA_STREAK=4 → grant pattern D,D,D,D,I repeating. No idle cycles occur, and exactly one rvalid per cycle from cycle 1 on.
- Back-to-back load (mem_rdata=0xAAAA5555) then fetch (mem_rdata=0x12345678) → d_rdata=0xAAAA5555 in cycle 1 and i_rdata=0x12345678 in cycle 2, with no cross-routing.
- rst_n pulsed low for half a cycle right after a data read grant → d_rvalid stays 0, all outputs are 0 during reset, and the streak counter restarts at 0.
- i_req dropped after 3 data grants, then reasserted together with d_req → the streak restarts, giving 4 data grants before the instruction grant.
